// File: rtl/paint_region.sv
// Rectangle fill engine: raster-order pixel writes with valid/ready backpressure.
// Optional screen clipping is enabled by defining PAINT_REGION_CLIP_EN.
module paint_region #(
  parameter int COOR_WIDTH    = 12,
  parameter int SCREEN_W      = 1280,
  parameter int SCREEN_H      = 300,
  parameter int PALETTE_WIDTH = 2
) (
  input  logic                     clk_33m,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [COOR_WIDTH-1:0]    rect_x,
  input  logic [COOR_WIDTH-1:0]    rect_y,
  input  logic [COOR_WIDTH-1:0]    rect_w,
  input  logic [COOR_WIDTH-1:0]    rect_h,
  input  logic [PALETTE_WIDTH-1:0] palette_a,
  input  logic [PALETTE_WIDTH-1:0] palette_b,
  input  logic                     mode,
  output logic [COOR_WIDTH-1:0]    write_x,
  output logic [COOR_WIDTH-1:0]    write_y,
  output logic [PALETTE_WIDTH-1:0] write_palette,
  output logic                     write_valid,
  input  logic                     write_ready,
  output logic                     busy,
  output logic                     done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PAINT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]               state;
  logic [COOR_WIDTH-1:0]    bx, by, bw, bh, dx, dy;
  logic [PALETTE_WIDTH-1:0] pa, pb;
  logic                     md;
  logic [COOR_WIDTH-1:0]    eff_w, eff_h;
  logic                     row_end, last, fire;

`ifdef PAINT_REGION_CLIP_EN
  localparam logic [COOR_WIDTH-1:0] SW = COOR_WIDTH'(SCREEN_W);
  localparam logic [COOR_WIDTH-1:0] SH = COOR_WIDTH'(SCREEN_H);
  logic [COOR_WIDTH-1:0] room_w, room_h;

  always_comb begin
    room_w = SW - rect_x;
    room_h = SH - rect_y;
    eff_w  = '0;
    eff_h  = '0;
    if (rect_x < SW)
      eff_w = (rect_w < room_w) ? rect_w : room_w;
    if (rect_y < SH)
      eff_h = (rect_h < room_h) ? rect_h : room_h;
  end
`else
  assign eff_w = rect_w;
  assign eff_h = rect_h;
`endif

  assign write_valid = (state == PAINT);
  assign busy        = (state == PAINT);
  assign done        = (state == DONE);

  assign row_end = (dx == bw - 1'b1);
  assign last    = row_end && (dy == bh - 1'b1);
  assign fire    = write_valid && write_ready;

  always_comb begin
    write_x       = '0;
    write_y       = '0;
    write_palette = '0;
    if (write_valid) begin
      write_x       = bx + dx;
      write_y       = by + dy;
      write_palette = (md && (dx[0] ^ dy[0])) ? pb : pa;
    end
  end

  always_ff @(posedge clk_33m or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      bx    <= '0;
      by    <= '0;
      bw    <= '0;
      bh    <= '0;
      dx    <= '0;
      dy    <= '0;
      pa    <= '0;
      pb    <= '0;
      md    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            bx    <= rect_x;
            by    <= rect_y;
            bw    <= eff_w;
            bh    <= eff_h;
            pa    <= palette_a;
            pb    <= palette_b;
            md    <= mode;
            dx    <= '0;
            dy    <= '0;
            // An empty region still reports completion.
            state <= (eff_w == '0 || eff_h == '0) ? DONE : PAINT;
          end
        end
        PAINT: begin
          if (fire) begin
            if (last) begin
              dx    <= '0;
              dy    <= '0;
              state <= DONE;
            end else if (row_end) begin
              dx <= '0;
              dy <= dy + 1'b1;
            end else begin
              dx <= dx + 1'b1;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_paint_region.sv
// Bench for paint_region: directed and random fills against a pixel-list model.
module tb_paint_region;
  localparam int CW = 12;
  localparam int PW = 2;
  localparam int SW = 1280;
  localparam int SH = 300;

  logic          clk_33m = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] rect_x = '0, rect_y = '0, rect_w = '0, rect_h = '0;
  logic [PW-1:0] palette_a = '0, palette_b = '0;
  logic          mode = 1'b0;
  logic [CW-1:0] write_x, write_y;
  logic [PW-1:0] write_palette;
  logic          write_valid, write_ready = 1'b0, busy, done;

  paint_region dut (
    .clk_33m(clk_33m), .rst_n(rst_n), .start(start),
    .rect_x(rect_x), .rect_y(rect_y), .rect_w(rect_w), .rect_h(rect_h),
    .palette_a(palette_a), .palette_b(palette_b), .mode(mode),
    .write_x(write_x), .write_y(write_y), .write_palette(write_palette),
    .write_valid(write_valid), .write_ready(write_ready),
    .busy(busy), .done(done)
  );

  always #15 clk_33m = ~clk_33m;

  typedef struct { int x; int y; int p; } beat_t;
  beat_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected pixel list in raster order.
  task automatic build(input int x, input int y, input int w, input int h,
                       input int pa, input int pb, input int md);
    int ew, eh;
    ew = w;
    eh = h;
`ifdef PAINT_REGION_CLIP_EN
    ew = (x >= SW) ? 0 : ((w < SW - x) ? w : SW - x);
    eh = (y >= SH) ? 0 : ((h < SH - y) ? h : SH - y);
`endif
    q.delete();
    for (int r = 0; r < eh; r++)
      for (int c = 0; c < ew; c++) begin
        beat_t b;
        b.x = (x + c) % 4096;
        b.y = (y + r) % 4096;
        b.p = (md == 1 && ((c + r) % 2) == 1) ? pb : pa;
        q.push_back(b);
      end
  endtask

  task automatic scramble();
    rect_x    = CW'($urandom);
    rect_y    = CW'($urandom);
    rect_w    = CW'($urandom);
    rect_h    = CW'($urandom);
    palette_a = PW'($urandom);
    palette_b = PW'($urandom);
    mode      = 1'($urandom);
  endtask

  task automatic check_beat();
    chk("valid", 32'(write_valid), 1);
    chk("busy", 32'(busy), 1);
    chk("done_mid", 32'(done), 0);
    chk("wx", 32'(write_x), q[0].x);
    chk("wy", 32'(write_y), q[0].y);
    chk("wpal", 32'(write_palette), q[0].p);
  endtask

  task automatic launch(input int x, input int y, input int w, input int h,
                        input int pa, input int pb, input int md);
    build(x, y, w, h, pa, pb, md);
    @(negedge clk_33m);
    rect_x = CW'(x); rect_y = CW'(y); rect_w = CW'(w); rect_h = CW'(h);
    palette_a = PW'(pa); palette_b = PW'(pb); mode = 1'(md);
    start = 1'b1;
    @(negedge clk_33m);
    start = 1'b0;
    scramble();
  endtask

  // rmode: 0 ready high, 1 random ready, 2 ready low on offered cycles 2-4
  task automatic run_fill(input int x, input int y, input int w, input int h,
                          input int pa, input int pb, input int md,
                          input int rmode);
    int n, got, cyc;
    bit acc;
    got = 0;
    cyc = 0;
    launch(x, y, w, h, pa, pb, md);
    n = q.size();
    if (n == 0) begin
      chk("zero_done", 32'(done), 1);
      chk("zero_valid", 32'(write_valid), 0);
      chk("zero_busy", 32'(busy), 0);
      @(negedge clk_33m);
      chk("zero_done_end", 32'(done), 0);
      return;
    end
    while (q.size() > 0 && cyc < 8 * n + 20) begin
      check_beat();
      cyc++;
      case (rmode)
        0:       write_ready = 1'b1;
        2:       write_ready = !(cyc >= 2 && cyc <= 4);
        default: write_ready = 1'($urandom);
      endcase
      start = 1'($urandom);
      scramble();
      acc = write_ready;
      @(negedge clk_33m);
      if (acc) begin
        void'(q.pop_front());
        got++;
      end
    end
    chk("timeout_left", 32'(q.size()), 0);
    chk("beats", 32'(got), 32'(n));
    chk("done_pulse", 32'(done), 1);
    chk("valid_done", 32'(write_valid), 0);
    chk("busy_done", 32'(busy), 0);
    start = 1'b0;
    @(negedge clk_33m);
    chk("done_end", 32'(done), 0);
    chk("valid_idle", 32'(write_valid), 0);
  endtask

  initial begin
    #1;
    chk("rst_valid", 32'(write_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_wx", 32'(write_x), 0);
    chk("rst_wy", 32'(write_y), 0);
    chk("rst_wpal", 32'(write_palette), 0);
    @(negedge clk_33m);
    rst_n = 1'b1;

    run_fill(10, 5, 3, 2, 3, 0, 0, 0);
    run_fill(0, 0, 2, 2, 1, 2, 1, 0);
    run_fill(7, 9, 4, 1, 2, 1, 0, 2);
    run_fill(4, 4, 0, 7, 1, 1, 0, 0);
    run_fill(1278, 299, 5, 5, 2, 1, 1, 0);
    run_fill(4094, 4095, 3, 2, 1, 3, 1, 1);

    // Reset in the middle of a 10-beat row.
    launch(20, 30, 10, 1, 1, 0, 0);
    write_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check_beat();
      @(negedge clk_33m);
      void'(q.pop_front());
    end
    rst_n = 1'b0;
    #1;
    chk("abort_valid", 32'(write_valid), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    @(negedge clk_33m);
    rst_n = 1'b1;
    @(negedge clk_33m);
    chk("abort_no_done", 32'(done), 0);
    run_fill(20, 30, 10, 1, 1, 0, 0, 0);

    for (int t = 0; t < 30; t++) begin
      int x, y;
      x = ($urandom % 3 == 0) ? int'(SW - 3 + $urandom % 6) : int'($urandom % 4096);
      y = ($urandom % 3 == 0) ? int'(SH - 3 + $urandom % 6) : int'($urandom % 4096);
      run_fill(x, y, $urandom % 7, $urandom % 6, $urandom % 4,
               $urandom % 4, $urandom % 2, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
